id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage of the MIPS pipeline; the producer side of the ALU's opcode/funct/operand interface.
- Accepts fetched instruction words over a valid/ready handshake and drives the register-file read addresses.
- Builds the ALU operands and control bits into a registered ID/EX bundle.
- Detects load-use hazards and inserts bubbles; supports flush.

Parameters:
- STALL_CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  clock
- reset  input  1  reset; synchronous, active-high
- flush  input  1  discard held ID/EX contents and the incoming instruction
- if_valid  input  1  fetch presents an instruction
- if_instr  input  32  instruction word
- if_pc  input  32  instruction address
- if_ready  output  1  stage accepts if_instr this cycle
- rf_raddr1  output  5  register-file read address (rs), combinational from if_instr
- rf_raddr2  output  5  register-file read address (rt), combinational from if_instr
- rf_rdata1  input  32  combinational read data; includes same-cycle writeback bypass
- rf_rdata2  input  32  combinational read data; includes same-cycle writeback bypass
- ex_valid  output  1  ID/EX bundle valid
- ex_ready  input  1  ALU stage consumes bundle
- ex_opcode  output  6  to ALU opcode
- ex_funct  output  6  to ALU funct
- ex_in1  output  32  ALU in1
- ex_in2  output  32  ALU in2
- ex_store_data  output  32  rt data for SW
- ex_dest  output  5  writeback register
- ex_reg_write  output  1  writeback enable
- ex_mem_read  output  1  LW
- ex_mem_write  output  1  SW
- ex_illegal  output  1  unsupported encoding
- ex_pc  output  32  instruction address
- stall_count  output  STALL_CNT_W  hazard bubbles inserted, saturating

Behaviour:
- Reset values: all ex_* outputs 0 (ex_valid=0) and stall_count=0.
- advance = !ex_valid || ex_ready.
- hazard = ex_valid && ex_mem_read && ex_dest!=0 && ((uses_rs && rs==ex_dest) || (uses_rt && rt==ex_dest)).
- if_ready = advance && !hazard, or 1 when flush.
- Transfer occurs when if_valid && if_ready. The bundle is registered, so there is one cycle of latency from acceptance to ex_valid.
- Bubble insertion: on advance && hazard, load a bubble (ex_valid=0, all controls 0) and increment stall_count, saturating at all-ones. The next cycle the ex register holds the bubble, so hazard clears and the instruction is accepted. Load-use therefore costs exactly 1 bubble.
- advance && !if_valid && !hazard: ex_valid becomes 0; no count.
- !advance: ex_* hold and if_ready=0.
- Flush has priority over everything except reset:
  - ex_valid becomes 0.
  - if_ready=1, and any presented instruction is consumed and dropped.
  - stall_count is unchanged.
- Decode uses standard MIPS field positions. Immediates are always sign-extended, including ADDIU.
  - R-type (opcode 0), funct ADD/ADDU/SUB/SUBU/SLT/SLTU:
    - in1=rs data, in2=rt data.
    - dest=rd, reg_write=(rd!=0).
    - Reads rs and rt.
  - Instruction word 0x00000000 (NOOP): reads nothing, reg_write=0, opcode and funct passed as 0.
  - Any other R-type word with funct NOOP, or any other funct:
    - ex_illegal=1, reg_write=0, mem_read=0, mem_write=0.
    - ex_valid=1, ex_opcode=0, ex_funct=0.
    - Reads nothing.
  - ADDI/ADDIU:
    - in1=rs data, in2=sext(imm).
    - dest=rt, reg_write=(rt!=0).
    - Reads rs.
  - LW:
    - As ADDI, plus mem_read=1.
    - dest=rt even if rt=0, but reg_write=0 in that case; the hazard check ignores dest 0.
  - SW:
    - in1=rs, in2=sext(imm), store_data=rt data.
    - mem_write=1, reg_write=0, dest=0.
    - Reads rs and rt.
  - Any other opcode: illegal, handled as for illegal R-type.
- ex_pc latched with the instruction.
- An accepted instruction is never duplicated or lost unless flushed.

Test Plan:
- Reset held 2 cycles while if_valid=1 -> ex_valid=0, stall_count=0, all ex_* 0. First cycle after reset, if_ready=1.
- ADD r3,r1,r2 (0x00221820) with rf_rdata1=5, rf_rdata2=7, ex_ready=1 -> next cycle:
  - ex_valid=1, opcode 0, funct 0x20, in1=5, in2=7.
  - dest=3, reg_write=1.
- ADDIU r4,r0,0xFFFF -> in2=0xFFFFFFFF, dest=4. SW r2,8(r1) -> in2=8, store_data=rt data, mem_write=1, reg_write=0.
- LW r5,0(r1) followed by ADD r6,r5,r2:
  - One cycle with ex_valid=0 between them; if_ready low for that cycle.
  - stall_count=1. ADD then issued with correct operands.
  - Repeat with ADD r6,r7,r2: no bubble.
- Backpressure: ex_ready=0 for 3 cycles with a valid bundle -> ex_* stable and if_ready=0. Release -> next instruction follows with no loss.
- Illegal opcode 0x3F, then flush asserted with a valid bundle and if_valid=1:
  - Illegal opcode gives ex_illegal=1, reg_write=0.
  - Flush gives ex_valid=0 next cycle and the input is dropped; stall_count unchanged.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes fetched words into a registered ID/EX
// bundle for the ALU, drives register-file read addresses, and inserts a
// single bubble on load-use dependencies.
module id_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    input  logic [31:0]            if_pc,
    output logic                   if_ready,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [31:0]            rf_rdata1,
    input  logic [31:0]            rf_rdata2,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [5:0]             ex_opcode,
    output logic [5:0]             ex_funct,
    output logic [31:0]            ex_in1,
    output logic [31:0]            ex_in2,
    output logic [31:0]            ex_store_data,
    output logic [4:0]             ex_dest,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_illegal,
    output logic [31:0]            ex_pc,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_SLT    = 6'h2A;
    localparam logic [5:0] F_SLTU   = 6'h2B;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
        logic [31:0] pc;
    } bundle_t;

    bundle_t                ex_q, ex_d, dec;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   uses_rs, uses_rt;
    logic                   advance, hazard;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm;

    assign opcode = if_instr[31:26];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign rd     = if_instr[15:11];
    assign funct  = if_instr[5:0];
    assign simm   = {{16{if_instr[15]}}, if_instr[15:0]};

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    // Decode the presented word into a candidate bundle and its source usage
    always_comb begin
        dec       = '0;
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        dec.valid = 1'b1;
        dec.pc    = if_pc;
        case (opcode)
            OP_RTYPE: begin
                // The all-zero word is a NOOP: valid but no effect.
                if (if_instr != 32'h0) begin
                    case (funct)
                        F_ADD, F_ADDU, F_SUB, F_SUBU, F_SLT, F_SLTU: begin
                            dec.funct     = funct;
                            dec.in1       = rf_rdata1;
                            dec.in2       = rf_rdata2;
                            dec.dest      = rd;
                            dec.reg_write = (rd != 5'd0);
                            uses_rs       = 1'b1;
                            uses_rt       = 1'b1;
                        end
                        default: dec.illegal = 1'b1;
                    endcase
                end
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                dec.opcode    = opcode;
                dec.in1       = rf_rdata1;
                dec.in2       = simm;
                dec.dest      = rt;
                dec.reg_write = (rt != 5'd0);
                dec.mem_read  = (opcode == OP_LW);
                uses_rs       = 1'b1;
            end
            OP_SW: begin
                dec.opcode     = opcode;
                dec.in1        = rf_rdata1;
                dec.in2        = simm;
                dec.store_data = rf_rdata2;
                dec.mem_write  = 1'b1;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // A load in EX whose target is read by the incoming word forces one bubble
    assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0) &&
                    ((uses_rs && (rs == ex_q.dest)) || (uses_rt && (rt == ex_q.dest)));
    assign advance  = !ex_q.valid || ex_ready;
    assign if_ready = flush || (advance && !hazard);

    // Next ID/EX bundle and bubble count
    always_comb begin
        ex_d    = ex_q;
        stall_d = stall_q;
        if (flush) begin
            ex_d = '0;
        end else if (advance) begin
            if (hazard) begin
                ex_d = '0;
                if (stall_q != '1) begin
                    stall_d = stall_q + STALL_CNT_W'(1);
                end
            end else if (if_valid) begin
                ex_d = dec;
            end else begin
                ex_d = '0;
            end
        end
    end

    // ID/EX register and bubble counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            stall_q <= '0;
        end else begin
            ex_q    <= ex_d;
            stall_q <= stall_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_opcode     = ex_q.opcode;
    assign ex_funct      = ex_q.funct;
    assign ex_in1        = ex_q.in1;
    assign ex_in2        = ex_q.in2;
    assign ex_store_data = ex_q.store_data;
    assign ex_dest       = ex_q.dest;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_illegal    = ex_q.illegal;
    assign ex_pc         = ex_q.pc;
    assign stall_count   = stall_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed test-plan sequence with literal expectations,
// then randomized traffic against a behavioural model checked every cycle.
module tb_id_stage;

    localparam int W       = 3;
    localparam int CNT_MAX = (1 << W) - 1;

    logic        clk = 1'b0;
    logic        reset, flush, if_valid, ex_ready;
    logic [31:0] if_instr, if_pc, rf_rdata1, rf_rdata2;
    logic        if_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
    logic [4:0]  rf_raddr1, rf_raddr2, ex_dest;
    logic [5:0]  ex_opcode, ex_funct;
    logic [31:0] ex_in1, ex_in2, ex_store_data, ex_pc;
    logic [W-1:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    id_stage #(.STALL_CNT_W(W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_illegal(ex_illegal), .ex_pc(ex_pc), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
        logic [31:0] pc;
    } bundle_t;

    typedef struct packed {
        bundle_t b;
        logic    reads_rs;
        logic    reads_rt;
    } dec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction meaning taken straight from the MIPS field definitions
    function automatic dec_t decode(input logic [31:0] w, input logic [31:0] pc,
                                    input logic [31:0] d1, input logic [31:0] d2);
        dec_t        r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] simm;
        r = '0;
        op = w[31:26];
        fn = w[5:0];
        simm = {{16{w[15]}}, w[15:0]};
        r.b.valid = 1'b1;
        r.b.pc = pc;
        if (w == 32'h0) begin
            r.reads_rs = 1'b0;
        end else if (op == 6'h00 && fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B}) begin
            r.b.funct = fn; r.b.in1 = d1; r.b.in2 = d2;
            r.b.dest = w[15:11]; r.b.reg_write = (w[15:11] != 0);
            r.reads_rs = 1'b1; r.reads_rt = 1'b1;
        end else if (op == 6'h08 || op == 6'h09 || op == 6'h23) begin
            r.b.opcode = op; r.b.in1 = d1; r.b.in2 = simm;
            r.b.dest = w[20:16]; r.b.reg_write = (w[20:16] != 0);
            r.b.mem_read = (op == 6'h23);
            r.reads_rs = 1'b1;
        end else if (op == 6'h2B) begin
            r.b.opcode = op; r.b.in1 = d1; r.b.in2 = simm; r.b.store_data = d2;
            r.b.mem_write = 1'b1;
            r.reads_rs = 1'b1; r.reads_rt = 1'b1;
        end else begin
            r.b.illegal = 1'b1;
        end
        return r;
    endfunction

    bundle_t m;
    int      mcnt;
    logic    started = 1'b0;

    function automatic logic m_hazard();
        dec_t d;
        d = decode(if_instr, if_pc, rf_rdata1, rf_rdata2);
        return m.valid && m.mem_read && m.dest != 0 &&
               ((d.reads_rs && if_instr[25:21] == m.dest) ||
                (d.reads_rt && if_instr[20:16] == m.dest));
    endfunction

    // Reference model of the ID/EX register and bubble counter
    always @(posedge clk) begin
        if (reset) begin
            m = '0;
            mcnt = 0;
            started = 1'b1;
        end else if (started) begin
            if (flush) begin
                m = '0;
            end else if (!m.valid || ex_ready) begin
                if (m_hazard()) begin
                    m = '0;
                    if (mcnt < CNT_MAX) mcnt++;
                end else if (if_valid) begin
                    m = decode(if_instr, if_pc, rf_rdata1, rf_rdata2).b;
                end else begin
                    m = '0;
                end
            end
        end
    end

    // Compare DUT against the model every cycle once reset has been seen
    always @(negedge clk) begin
        if (started) begin
            chk("if_ready", 32'(if_ready), 32'(flush || ((!m.valid || ex_ready) && !m_hazard())));
            chk("rf_raddr1", 32'(rf_raddr1), 32'(if_instr[25:21]));
            chk("rf_raddr2", 32'(rf_raddr2), 32'(if_instr[20:16]));
            chk("ex_valid", 32'(ex_valid), 32'(m.valid));
            chk("stall_count", 32'(stall_count), 32'(mcnt));
            chk("ex_reg_write", 32'(ex_reg_write), 32'(m.reg_write));
            chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mem_read));
            chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mem_write));
            chk("ex_illegal", 32'(ex_illegal), 32'(m.illegal));
            if (m.valid) begin
                chk("ex_opcode", 32'(ex_opcode), 32'(m.opcode));
                chk("ex_funct", 32'(ex_funct), 32'(m.funct));
                chk("ex_in1", ex_in1, m.in1);
                chk("ex_in2", ex_in2, m.in2);
                chk("ex_store_data", ex_store_data, m.store_data);
                chk("ex_dest", 32'(ex_dest), 32'(m.dest));
                chk("ex_pc", ex_pc, m.pc);
            end
        end
    end

    // Inputs change 1 time unit after the rising edge, then settle before checks
    task automatic apply(input logic rst, input logic fl, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                         input logic er);
        @(posedge clk);
        #1;
        reset = rst; flush = fl; if_valid = v; if_instr = ins; if_pc = pc;
        rf_rdata1 = d1; rf_rdata2 = d2; ex_ready = er;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  legal [6];
        legal = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B};
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        w = $urandom;
        case ($urandom_range(0, 9))
            0:       w = 32'h0;
            1, 2:    w = {6'h00, rs, rt, rd, 5'd0, legal[$urandom_range(0, 5)]};
            3:       w = {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
            4:       w = {6'h08 | 6'($urandom_range(0, 1)), rs, rt, w[15:0]};
            5, 6:    w = {6'h23, rs, rt, w[15:0]};
            7:       w = {6'h2B, rs, rt, w[15:0]};
            default: w = {6'($urandom), rs, rt, w[15:0]};
        endcase
        return w;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; if_valid = 1'b1; if_instr = 32'h00221820; if_pc = 32'h0;
        rf_rdata1 = 32'h0; rf_rdata2 = 32'h0; ex_ready = 1'b1;

        apply(1, 0, 1, 32'h00221820, 32'h0, 32'd5, 32'd7, 1);
        chk("rst ex_valid", 32'(ex_valid), 32'd0);
        chk("rst stall_count", 32'(stall_count), 32'd0);
        apply(0, 0, 0, 32'h0, 32'h0, 32'd0, 32'd0, 1);
        chk("rst ex bundle", {ex_in1 | ex_in2 | ex_store_data | ex_pc}, 32'd0);
        chk("rst ex ctrl", 32'({ex_opcode, ex_funct, ex_dest, ex_reg_write, ex_mem_read,
                                ex_mem_write, ex_illegal}), 32'd0);
        chk("post-rst if_ready", 32'(if_ready), 32'd1);

        apply(0, 0, 1, 32'h00221820, 32'h1000, 32'd5, 32'd7, 1);            // ADD r3,r1,r2
        chk("add raddr", 32'({rf_raddr1, rf_raddr2}), 32'({5'd1, 5'd2}));
        apply(0, 0, 1, 32'h2404FFFF, 32'h1004, 32'd9, 32'd0, 1);            // ADDIU r4,r0,-1
        chk("add valid", 32'(ex_valid), 32'd1);
        chk("add funct", 32'(ex_funct), 32'h20);
        chk("add in1/in2", {ex_in1[15:0], ex_in2[15:0]}, {16'd5, 16'd7});
        chk("add dest/rw", 32'({ex_dest, ex_reg_write}), 32'({5'd3, 1'b1}));
        chk("add pc", ex_pc, 32'h1000);
        apply(0, 0, 1, 32'hAC220008, 32'h1008, 32'h100, 32'hABCD, 1);       // SW r2,8(r1)
        chk("addiu in2", ex_in2, 32'hFFFFFFFF);
        chk("addiu dest", 32'(ex_dest), 32'd4);
        apply(0, 0, 1, 32'h8C250000, 32'h100C, 32'h200, 32'd0, 1);         // LW r5,0(r1)
        chk("sw in1/in2", {ex_in1[15:0], ex_in2[15:0]}, {16'h100, 16'd8});
        chk("sw store", ex_store_data, 32'hABCD);
        chk("sw mw/rw", 32'({ex_mem_write, ex_reg_write}), 32'b10);
        apply(0, 0, 1, 32'h00A23020, 32'h1010, 32'd11, 32'd22, 1);          // ADD r6,r5,r2
        chk("lw mr/dest", 32'({ex_mem_read, ex_dest}), 32'({1'b1, 5'd5}));
        chk("load-use if_ready", 32'(if_ready), 32'd0);
        apply(0, 0, 1, 32'h00A23020, 32'h1010, 32'd11, 32'd22, 1);
        chk("bubble ex_valid", 32'(ex_valid), 32'd0);
        chk("bubble stall_count", 32'(stall_count), 32'd1);
        chk("after bubble if_ready", 32'(if_ready), 32'd1);
        apply(0, 0, 1, 32'h8C250000, 32'h1014, 32'h200, 32'd0, 1);         // LW r5,0(r1)
        chk("dep add in1/in2", {ex_in1[15:0], ex_in2[15:0]}, {16'd11, 16'd22});
        chk("dep add dest", 32'({ex_valid, ex_dest}), 32'({1'b1, 5'd6}));
        apply(0, 0, 1, 32'h00E23020, 32'h1018, 32'd33, 32'd44, 1);          // ADD r6,r7,r2
        chk("indep if_ready", 32'(if_ready), 32'd1);
        apply(0, 0, 1, 32'h00430820, 32'h101C, 32'd1, 32'd2, 0);            // ADD r1,r2,r3
        chk("indep no bubble", 32'({ex_valid, ex_dest, ex_in1[7:0]}), 32'({1'b1, 5'd6, 8'd33}));
        chk("indep stall_count", 32'(stall_count), 32'd1);
        chk("bp if_ready", 32'(if_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 1, 32'h00430820, 32'h101C, 32'd1, 32'd2, 0);
            chk("bp hold", 32'({ex_valid, ex_dest, ex_in1[7:0]}), 32'({1'b1, 5'd6, 8'd33}));
            chk("bp if_ready", 32'(if_ready), 32'd0);
        end
        apply(0, 0, 1, 32'h00430820, 32'h101C, 32'd1, 32'd2, 1);
        chk("bp release hold", 32'({ex_valid, ex_dest}), 32'({1'b1, 5'd6}));
        apply(0, 0, 1, 32'hFC000000, 32'h1020, 32'd0, 32'd0, 1);            // opcode 0x3F
        chk("bp next dest", 32'({ex_valid, ex_dest, ex_in1[7:0]}), 32'({1'b1, 5'd1, 8'd1}));
        apply(0, 1, 1, 32'h00221820, 32'h1024, 32'd5, 32'd7, 1);            // flush
        chk("illegal", 32'({ex_valid, ex_illegal, ex_reg_write, ex_opcode}), 32'({1'b1, 1'b1, 1'b0, 6'd0}));
        chk("flush if_ready", 32'(if_ready), 32'd1);
        apply(0, 0, 0, 32'h0, 32'h1028, 32'd0, 32'd0, 1);
        chk("flush ex_valid", 32'(ex_valid), 32'd0);
        chk("flush stall_count", 32'(stall_count), 32'd1);
        apply(0, 0, 0, 32'h0, 32'h102C, 32'd0, 32'd0, 1);
        chk("flush dropped", 32'(ex_valid), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            apply(0, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
                  $urandom, $urandom, $urandom, ($urandom_range(0, 3) != 0));
        end
        apply(0, 0, 0, 32'h0, 32'h0, 32'd0, 32'd0, 1);
        chk("stall_count saturated", 32'(stall_count), 32'(CNT_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
